// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: fetch, decode and execute sequencing for a
// small accumulator CPU, with a decoded-instruction counter.
module cpu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mova,
    input  logic       movb,
    input  logic       movc,
    input  logic       add,
    input  logic       sub,
    input  logic       and1,
    input  logic       not1,
    input  logic       rsr,
    input  logic       rsl,
    input  logic       jmp,
    input  logic       jz,
    input  logic       jc,
    input  logic       in1,
    input  logic       out1,
    input  logic       nop,
    input  logic       halt,
    input  logic       zf,
    input  logic       cf,
    input  logic       mem_rdy,
    output logic       dec_en,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_we,
    output logic       flag_we,
    output logic [1:0] src_sel,
    output logic [2:0] alu_op,
    output logic       in_rd,
    output logic       out_we,
    output logic       halted,
    output logic [7:0] icount
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
    } state_t;

    typedef enum logic [4:0] {
        O_NOP, O_MOVA, O_MOVB, O_MOVC, O_ADD, O_SUB, O_AND, O_NOT,
        O_RSR, O_RSL, O_JMP, O_JZ, O_JC, O_JZC, O_IN, O_OUT, O_HALT
    } op_t;

    state_t state, nxt;
    op_t    op, dec_op;
    logic   taken;

    // Simultaneous lines resolve by fixed priority; jz+jc is its own op
    always_comb begin
        dec_op = O_NOP;
        priority case (1'b1)
            halt:       dec_op = O_HALT;
            jmp:        dec_op = O_JMP;
            (jz && jc): dec_op = O_JZC;
            jz:         dec_op = O_JZ;
            jc:         dec_op = O_JC;
            movc:       dec_op = O_MOVC;
            movb:       dec_op = O_MOVB;
            mova:       dec_op = O_MOVA;
            add:        dec_op = O_ADD;
            sub:        dec_op = O_SUB;
            and1:       dec_op = O_AND;
            not1:       dec_op = O_NOT;
            rsr:        dec_op = O_RSR;
            rsl:        dec_op = O_RSL;
            in1:        dec_op = O_IN;
            out1:       dec_op = O_OUT;
            nop:        dec_op = O_NOP;
            default:    dec_op = O_NOP;
        endcase
    end

    assign taken = (op == O_JMP)
                 | ((op == O_JZ)  & zf)
                 | ((op == O_JC)  & cf)
                 | ((op == O_JZC) & (zf | cf));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op     <= O_NOP;
            icount <= '0;
        end else begin
            state <= nxt;
            if (state == S_DECODE) begin
                op     <= dec_op;
                icount <= icount + 8'd1;
            end
        end
    end

    always_comb begin
        nxt     = state;
        dec_en  = 1'b0;
        ir_ld   = 1'b0;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        reg_we  = 1'b0;
        flag_we = 1'b0;
        src_sel = 2'b00;
        alu_op  = 3'b000;
        in_rd   = 1'b0;
        out_we  = 1'b0;
        halted  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_rdy) begin
                    ir_ld  = 1'b1;
                    pc_inc = 1'b1;
                    nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                dec_en = 1'b1;
                unique case (dec_op)
                    O_HALT:  nxt = S_HALT;
                    O_NOP:   nxt = S_FETCH;
                    default: nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                nxt = S_FETCH;
                unique case (op)
                    O_MOVA: reg_we = 1'b1;
                    O_ADD, O_SUB, O_AND, O_NOT, O_RSR, O_RSL: begin
                        reg_we  = 1'b1;
                        flag_we = 1'b1;
                        unique case (op)
                            O_ADD:   alu_op = 3'b001;
                            O_SUB:   alu_op = 3'b010;
                            O_AND:   alu_op = 3'b011;
                            O_NOT:   alu_op = 3'b100;
                            O_RSR:   alu_op = 3'b101;
                            O_RSL:   alu_op = 3'b110;
                            default: alu_op = 3'b000;
                        endcase
                    end
                    O_MOVC: begin
                        mem_rd = 1'b1;
                        if (mem_rdy) begin
                            reg_we  = 1'b1;
                            src_sel = 2'b01;
                        end else begin
                            nxt = S_EXEC;
                        end
                    end
                    O_MOVB: begin
                        mem_wr = 1'b1;
                        if (!mem_rdy) nxt = S_EXEC;
                    end
                    // Operand byte at PC: load it as target, or skip it
                    O_JMP, O_JZ, O_JC, O_JZC: begin
                        mem_rd = 1'b1;
                        if (mem_rdy) begin
                            pc_ld  = taken;
                            pc_inc = ~taken;
                        end else begin
                            nxt = S_EXEC;
                        end
                    end
                    O_IN: begin
                        in_rd   = 1'b1;
                        reg_we  = 1'b1;
                        src_sel = 2'b10;
                    end
                    O_OUT:   out_we = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: halted = 1'b1;
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 start  in  1  leaves IDLE when high; ignored in every other state.
REQ-004 mova,movb,movc,add,sub,and1,not1,rsr,rsl,jmp,jz,jc,in1,out1,nop,halt  in  1 each  one-hot decoded instruction lines from the instruction decoder; jz and jc may be high together.
REQ-005 zf, cf  in  1 each  registered zero and carry flags from the datapath.
REQ-006 mem_rdy  in  1  memory completes the current access in this cycle.
REQ-007 dec_en  out  1  enable to the instruction decoder.
REQ-008 ir_ld, pc_inc, pc_ld  out  1 each  IR load, PC increment and PC load strobes.
REQ-009 mem_rd, mem_wr  out  1 each  memory read and write requests.
REQ-010 reg_we, flag_we  out  1 each  register-file write strobe and flag-register write strobe.
REQ-011 src_sel  out  2  register write source: 00 ALU, 01 memory, 10 input port.
REQ-012 alu_op  out  3  ALU function: 000 pass A, 001 add, 010 sub, 011 and, 100 not, 101 shift right, 110 shift left.
REQ-013 in_rd, out_we  out  1 each  input-port read strobe and output-port write strobe.
REQ-014 halted  out  1  high while in HALT.
REQ-015 icount  out  8  count of decoded instructions.

Function
REQ-016 States SHALL be IDLE, FETCH, DECODE, EXEC, HALT; all outputs SHALL decode combinationally from state, latched op, zf, cf and mem_rdy.
REQ-017 IDLE: all outputs 0; start=1 -> FETCH.
REQ-018 FETCH: mem_rd=1 held; ir_ld=1 and pc_inc=1 only in the cycle where mem_rdy=1, which is also when the block moves to DECODE; mem_rdy=0 -> stay in FETCH.
REQ-019 DECODE: one cycle; dec_en=1; op latched from the decode lines at the clock edge; icount increments by 1 and wraps from 255 to 0.
REQ-020 DECODE exit: halt -> HALT; nop or no line high -> FETCH; otherwise -> EXEC.
REQ-021 Several lines high at once (jz+jc excepted) SHALL resolve by priority: halt, jmp, jz/jc, movc, movb, mova, add, sub, and1, not1, rsr, rsl, in1, out1, nop.
REQ-022 EXEC mova: reg_we=1, src_sel=00, alu_op=000 -> FETCH.
REQ-023 EXEC add/sub/and1/not1/rsr/rsl: reg_we=1, flag_we=1, src_sel=00, alu_op per REQ-012 -> FETCH.
REQ-024 EXEC movc: mem_rd=1 held; reg_we=1 and src_sel=01 only when mem_rdy=1, then -> FETCH.
REQ-025 EXEC movb: mem_wr=1 held until mem_rdy=1, then -> FETCH.
REQ-026 EXEC jmp/jz/jc: mem_rd=1 held (operand byte at PC) until mem_rdy=1; in that cycle pc_ld=1 if taken, else pc_inc=1; then -> FETCH.
REQ-027 Jump-taken rule: jmp always; jz only -> zf; jc only -> cf; jz and jc both -> zf|cf; flags sampled in the mem_rdy cycle.
REQ-028 EXEC in1: in_rd=1, reg_we=1, src_sel=10 -> FETCH; out1: out_we=1 -> FETCH; each one cycle.
REQ-029 HALT: halted=1, all other strobes 0; remains until reset.
REQ-030 pc_ld and pc_inc SHALL never be high in the same cycle; mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-031 Unused alu_op code 111 SHALL never be driven; the default is 000.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, clear op and icount, and drive every output to 0, including mid-access with mem_rd or mem_wr high.
REQ-033 After rst_n rises, the block SHALL remain in IDLE until start=1.

Verification
REQ-034 Reset, then start pulse, then add decoded, mem_rdy tied 1 -> FETCH, DECODE, EXEC in 3 cycles; EXEC has reg_we=1, flag_we=1, alu_op=001; icount=1.
REQ-035 FETCH with mem_rdy held 0 for 3 cycles -> mem_rd held 4 cycles; ir_ld and pc_inc high only in the 4th cycle.
REQ-036 jz with zf=0, then jz with zf=1, then jz+jc with zf=0 and cf=1 -> pc_inc, pc_ld, pc_ld respectively in the EXEC mem_rdy cycle.
REQ-037 halt decoded -> halted=1 permanently; start pulses ignored; rst_n low -> halted=0 and state IDLE.
REQ-038 256 nop instructions -> icount wraps to 0; rst_n low during EXEC movb with mem_rdy=0 -> mem_wr drops to 0 immediately.
